// File: rtl/ibex_shadow_stack_ctrl.sv
// Shadow-stack producer. Classifies retiring JAL/JALR instructions as calls
// (push) or returns (pop), queues them in a small FIFO and issues one event per
// cycle to the shadow stack. A same-cycle error from the stack latches a sticky
// alert that flushes the queue and disables decode until software clears it.
module ibex_shadow_stack_ctrl #(
   parameter int unsigned FifoDepth = 4,
   parameter bit          LinkX5    = 1'b1
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        instr_valid_i,
   input  logic [31:0] instr_i,
   input  logic        instr_is_comp_i,
   input  logic [31:0] pc_i,
   input  logic [31:0] jump_target_i,
   output logic        stall_o,
   output logic        push_valid_o,
   output logic [31:0] push_addr_o,
   output logic        pop_valid_o,
   output logic [31:0] pop_addr_o,
   input  logic        ss_error_i,
   input  logic        clear_i,
   output logic        alert_o
);

   localparam int unsigned PtrW = $clog2(FifoDepth);
   localparam int unsigned CntW = PtrW + 1;
   // Stall once fewer than two entries are free, so a dual-event JALR always fits.
   localparam logic [CntW-1:0] StallThr = CntW'(FifoDepth - 1);

   localparam logic [6:0] OpcJal  = 7'h6f;
   localparam logic [6:0] OpcJalr = 7'h67;

   typedef enum logic {
      StRun   = 1'b0,
      StAlert = 1'b1
   } state_e;

   typedef struct packed {
      logic        is_push;
      logic [31:0] addr;
   } ev_t;

   state_e                state_q, state_d;
   ev_t [FifoDepth-1:0]   mem_q, mem_d;
   logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
   logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0]       wr_ptr_nxt;
   logic [CntW-1:0]       cnt_q, cnt_d;

   logic                  running;
   logic                  issue;
   ev_t                   head;

   logic [6:0]            opcode;
   logic [4:0]            rd, rs1;
   logic [2:0]            funct3;
   logic                  rd_link, rs1_link;
   logic                  dec_en;
   logic [31:0]           link_addr;
   logic [1:0]            n_enq;
   ev_t                   ev0, ev1;

   logic                  unused_instr;

   function automatic logic is_link(input logic [4:0] r);
      return (r == 5'd1) || (LinkX5 && (r == 5'd5));
   endfunction

   // Instruction field extraction; the immediate bits are irrelevant here.
   assign opcode       = instr_i[6:0];
   assign rd           = instr_i[11:7];
   assign funct3       = instr_i[14:12];
   assign rs1          = instr_i[19:15];
   assign unused_instr = ^instr_i[31:20];
   assign rd_link      = is_link(rd);
   assign rs1_link     = is_link(rs1);

   // Everything visible downstream comes from registered state only.
   assign running      = (state_q == StRun);
   assign issue        = running && (cnt_q != '0);
   assign head         = mem_q[rd_ptr_q];
   assign stall_o      = running && (cnt_q >= StallThr);
   assign alert_o      = (state_q == StAlert);
   assign push_valid_o = issue && head.is_push;
   assign pop_valid_o  = issue && !head.is_push;
   assign push_addr_o  = push_valid_o ? head.addr : 32'h0;
   assign pop_addr_o   = pop_valid_o  ? head.addr : 32'h0;

   // An instruction presented while stalled is dropped, not buffered.
   assign dec_en       = instr_valid_i && !stall_o && running;
   assign link_addr    = pc_i + (instr_is_comp_i ? 32'd2 : 32'd4);
   assign wr_ptr_nxt   = wr_ptr_q + PtrW'(1);

   // Classify the retiring instruction into zero, one or two queue events.
   always_comb begin
      n_enq = 2'd0;
      ev0   = '0;
      ev1   = '0;
      if (dec_en) begin
         if (opcode == OpcJal) begin
            if (rd_link) begin
               n_enq = 2'd1;
               ev0   = '{is_push: 1'b1, addr: link_addr};
            end
         end else if ((opcode == OpcJalr) && (funct3 == 3'b000)) begin
            if (rd_link && rs1_link && (rd != rs1)) begin
               // Coroutine swap: validate the return first, then record the new link.
               n_enq = 2'd2;
               ev0   = '{is_push: 1'b0, addr: jump_target_i};
               ev1   = '{is_push: 1'b1, addr: link_addr};
            end else if (rd_link) begin
               n_enq = 2'd1;
               ev0   = '{is_push: 1'b1, addr: link_addr};
            end else if (rs1_link) begin
               n_enq = 2'd1;
               ev0   = '{is_push: 1'b0, addr: jump_target_i};
            end
         end
      end
   end

   // FSM and FIFO next state: an error on an issued request flushes and alerts.
   always_comb begin
      state_d  = state_q;
      mem_d    = mem_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      cnt_d    = cnt_q;
      unique case (state_q)
         StRun: begin
            if (issue && ss_error_i) begin
               state_d  = StAlert;
               rd_ptr_d = '0;
               wr_ptr_d = '0;
               cnt_d    = '0;
            end else begin
               if (issue) begin
                  rd_ptr_d = rd_ptr_q + PtrW'(1);
               end
               if (n_enq != 2'd0) begin
                  mem_d[wr_ptr_q] = ev0;
               end
               if (n_enq == 2'd2) begin
                  mem_d[wr_ptr_nxt] = ev1;
               end
               wr_ptr_d = wr_ptr_q + PtrW'(n_enq);
               cnt_d    = cnt_q + CntW'(n_enq) - CntW'(issue);
            end
         end
         StAlert: begin
            if (clear_i) begin
               state_d = StRun;
            end
         end
         default: state_d = StRun;
      endcase
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= StRun;
         mem_q    <= '0;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         mem_q    <= mem_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   // Structural invariants of the queue and request interface.
   a_one_req: assert property (@(posedge clk_i) disable iff (!rst_ni)
      !(push_valid_o && pop_valid_o));
   a_cnt_bound: assert property (@(posedge clk_i) disable iff (!rst_ni)
      cnt_q <= CntW'(FifoDepth));
   a_alert_empty: assert property (@(posedge clk_i) disable iff (!rst_ni)
      alert_o |-> (cnt_q == '0));

endmodule

// File: tb/tb_ibex_shadow_stack_ctrl.sv
// Bench for ibex_shadow_stack_ctrl: directed scenarios plus a randomized run,
// all checked against a queue-level model of the event stream.
module tb_ibex_shadow_stack_ctrl;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst_ni;
   logic        instr_valid;
   logic [31:0] instr;
   logic        comp;
   logic [31:0] pc;
   logic [31:0] tgt;
   logic        ss_error;
   logic        clear;

   logic        stall, push_v, pop_v, alert;
   logic [31:0] push_a, pop_a;
   logic        x_stall, x_push_v, x_pop_v, x_alert;
   logic [31:0] x_push_a, x_pop_a;

   int tests_run    = 0;
   int tests_failed = 0;

   always #5 clk = ~clk;

   ibex_shadow_stack_ctrl #(.FifoDepth(DEPTH), .LinkX5(1'b1)) u_dut (
      .clk_i(clk), .rst_ni(rst_ni), .instr_valid_i(instr_valid), .instr_i(instr),
      .instr_is_comp_i(comp), .pc_i(pc), .jump_target_i(tgt), .stall_o(stall),
      .push_valid_o(push_v), .push_addr_o(push_a), .pop_valid_o(pop_v),
      .pop_addr_o(pop_a), .ss_error_i(ss_error), .clear_i(clear), .alert_o(alert)
   );

   ibex_shadow_stack_ctrl #(.FifoDepth(DEPTH), .LinkX5(1'b0)) u_dut_x1 (
      .clk_i(clk), .rst_ni(rst_ni), .instr_valid_i(instr_valid), .instr_i(instr),
      .instr_is_comp_i(comp), .pc_i(pc), .jump_target_i(tgt), .stall_o(x_stall),
      .push_valid_o(x_push_v), .push_addr_o(x_push_a), .pop_valid_o(x_pop_v),
      .pop_addr_o(x_pop_a), .ss_error_i(ss_error), .clear_i(clear), .alert_o(x_alert)
   );

   // ---------------- reference model (LinkX5 = 1 instance) ----------------
   typedef struct {
      bit          is_push;
      logic [31:0] addr;
   } mev_t;

   mev_t mq[$];
   bit   m_alert = 1'b0;

   function automatic bit lnk(input logic [4:0] r);
      return (r == 5'd1) || (r == 5'd5);
   endfunction

   function automatic bit m_stall();
      return !m_alert && ((DEPTH - int'(mq.size())) < 2);
   endfunction

   // Expected {stall, push_v, push_a, pop_v, pop_a, alert}.
   function automatic logic [67:0] exp_vec();
      logic        pv = 1'b0, qv = 1'b0;
      logic [31:0] pa = 32'h0, qa = 32'h0;
      if (!m_alert && mq.size() > 0) begin
         if (mq[0].is_push) begin pv = 1'b1; pa = mq[0].addr; end
         else               begin qv = 1'b1; qa = mq[0].addr; end
      end
      return {m_stall(), pv, pa, qv, qa, m_alert};
   endfunction

   function automatic logic [67:0] dut_vec();
      return {stall, push_v, push_a, pop_v, pop_a, alert};
   endfunction

   task automatic model_decode();
      logic [6:0]  op  = instr[6:0];
      logic [4:0]  rd  = instr[11:7];
      logic [4:0]  rs1 = instr[19:15];
      logic [2:0]  f3  = instr[14:12];
      logic [31:0] ra  = pc + (comp ? 32'd2 : 32'd4);
      if (op == 7'h6f) begin
         if (lnk(rd)) mq.push_back('{1'b1, ra});
      end else if (op == 7'h67 && f3 == 3'd0) begin
         if (lnk(rd) && lnk(rs1) && rd != rs1) begin
            mq.push_back('{1'b0, tgt});
            mq.push_back('{1'b1, ra});
         end else if (lnk(rd)) mq.push_back('{1'b1, ra});
         else if (lnk(rs1))    mq.push_back('{1'b0, tgt});
      end
   endtask

   // Advance the model by the clock edge about to happen, then move to the next negedge.
   task automatic tick();
      bit iss = !m_alert && (mq.size() > 0);
      bit stl = m_stall();
      if (m_alert) begin
         if (clear) m_alert = 1'b0;
      end else if (iss && ss_error) begin
         m_alert = 1'b1;
         mq.delete();
      end else begin
         if (iss) void'(mq.pop_front());
         if (instr_valid && !stl) model_decode();
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle();
      instr_valid = 1'b0; instr = 32'h0; comp = 1'b0; pc = 32'h0; tgt = 32'h0;
      ss_error = 1'b0; clear = 1'b0;
   endtask

   function automatic logic [31:0] jal(input logic [4:0] rd);
      return {20'h0, rd, 7'h6f};
   endfunction

   function automatic logic [31:0] jalr(input logic [4:0] rd, input logic [4:0] rs1);
      return {12'h0, rs1, 3'b000, rd, 7'h67};
   endfunction

   task automatic do_reset();
      rst_ni = 1'b0;
      mq.delete();
      m_alert = 1'b0;
      idle();
      @(negedge clk);
      @(negedge clk);
      rst_ni = 1'b1;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      idle();
      rst_ni = 1'b0;
      #1;
      tests_run++;
      if (dut_vec() !== 68'h0) begin
         tests_failed++;
         $display("FAIL reset_outs: got %h want %h", dut_vec(), 68'h0);
      end
      @(negedge clk);
      rst_ni = 1'b1;
      tick();
      tests_run++;
      if (dut_vec() !== exp_vec()) begin
         tests_failed++;
         $display("FAIL reset_idle: got %h want %h", dut_vec(), exp_vec());
      end
   endtask

   task automatic test_jal_push();
      instr = jal(5'd1); pc = 32'h100; instr_valid = 1'b1;
      #1;
      tests_run++;
      if (push_v !== 1'b0) begin
         tests_failed++;
         $display("FAIL jal_no_bypass: got push_v=%b want 0", push_v);
      end
      tick();
      idle();
      tests_run++;
      if (push_v !== 1'b1 || push_a !== 32'h104 || pop_v !== 1'b0) begin
         tests_failed++;
         $display("FAIL jal_push: got v=%b a=%h pop=%b want v=1 a=00000104 pop=0", push_v, push_a, pop_v);
      end
      tick();
      tests_run++;
      if (push_v !== 1'b0 || dut_vec() !== exp_vec()) begin
         tests_failed++;
         $display("FAIL jal_one_cycle: got %h want %h", dut_vec(), exp_vec());
      end
   endtask

   task automatic test_call_return();
      instr = jalr(5'd1, 5'd10); comp = 1'b1; pc = 32'h200; tgt = 32'h3000; instr_valid = 1'b1;
      tick();
      instr = jalr(5'd0, 5'd1); comp = 1'b0; pc = 32'h3000; tgt = 32'h202;
      tests_run++;
      if (push_v !== 1'b1 || push_a !== 32'h202) begin
         tests_failed++;
         $display("FAIL cjalr_push: got v=%b a=%h want v=1 a=00000202", push_v, push_a);
      end
      tick();
      idle();
      tests_run++;
      if (pop_v !== 1'b1 || pop_a !== 32'h202 || push_v !== 1'b0) begin
         tests_failed++;
         $display("FAIL ret_pop: got v=%b a=%h push=%b want v=1 a=00000202 push=0", pop_v, pop_a, push_v);
      end
      tick();
      tests_run++;
      if (alert !== 1'b0 || dut_vec() !== exp_vec()) begin
         tests_failed++;
         $display("FAIL ret_no_alert: got %h want %h", dut_vec(), exp_vec());
      end
   endtask

   task automatic test_coroutine();
      do_reset();
      instr = jalr(5'd1, 5'd5); pc = 32'h300; tgt = 32'h400; instr_valid = 1'b1;
      tick();
      idle();
      tests_run++;
      if (pop_v !== 1'b1 || pop_a !== 32'h400 || push_v !== 1'b0) begin
         tests_failed++;
         $display("FAIL corout_pop: got v=%b a=%h want v=1 a=00000400", pop_v, pop_a);
      end
      tests_run++;
      if (x_push_v !== 1'b1 || x_push_a !== 32'h304 || x_pop_v !== 1'b0) begin
         tests_failed++;
         $display("FAIL x1only_push: got v=%b a=%h pop=%b want v=1 a=00000304 pop=0", x_push_v, x_push_a, x_pop_v);
      end
      tick();
      tests_run++;
      if (push_v !== 1'b1 || push_a !== 32'h304 || pop_v !== 1'b0) begin
         tests_failed++;
         $display("FAIL corout_push: got v=%b a=%h want v=1 a=00000304", push_v, push_a);
      end
      tests_run++;
      if (x_push_v !== 1'b0 || x_pop_v !== 1'b0) begin
         tests_failed++;
         $display("FAIL x1only_single: got push=%b pop=%b want 0 0", x_push_v, x_pop_v);
      end
      tick();
      tests_run++;
      if (dut_vec() !== exp_vec()) begin
         tests_failed++;
         $display("FAIL corout_drain: got %h want %h", dut_vec(), exp_vec());
      end
   endtask

   task automatic test_alert();
      // Error with nothing issued is ignored.
      ss_error = 1'b1;
      tick();
      ss_error = 1'b0;
      tests_run++;
      if (alert !== 1'b0) begin
         tests_failed++;
         $display("FAIL err_ignored: got alert=%b want 0", alert);
      end
      instr = jalr(5'd0, 5'd1); tgt = 32'h500; instr_valid = 1'b1;
      tick();
      instr = jal(5'd1); pc = 32'h510;   // queued this cycle, must be flushed
      ss_error = 1'b1;
      tick();
      idle();
      tests_run++;
      if (alert !== 1'b1 || push_v !== 1'b0 || pop_v !== 1'b0 || stall !== 1'b0) begin
         tests_failed++;
         $display("FAIL alert_enter: got alert=%b push=%b pop=%b stall=%b want 1 0 0 0", alert, push_v, pop_v, stall);
      end
      instr = jal(5'd1); pc = 32'h520; instr_valid = 1'b1;
      tick();
      tick();
      idle();
      tests_run++;
      if (push_v !== 1'b0 || alert !== 1'b1 || dut_vec() !== exp_vec()) begin
         tests_failed++;
         $display("FAIL alert_no_decode: got %h want %h", dut_vec(), exp_vec());
      end
      clear = 1'b1;
      tick();
      idle();
      tests_run++;
      if (alert !== 1'b0) begin
         tests_failed++;
         $display("FAIL alert_clear: got alert=%b want 0", alert);
      end
      instr = jal(5'd1); pc = 32'h600; instr_valid = 1'b1;
      tick();
      idle();
      tests_run++;
      if (push_v !== 1'b1 || push_a !== 32'h604) begin
         tests_failed++;
         $display("FAIL decode_resume: got v=%b a=%h want v=1 a=00000604", push_v, push_a);
      end
      instr = jalr(5'd0, 5'd5); tgt = 32'h700; instr_valid = 1'b1;
      tick();
      idle();
      ss_error = 1'b1; clear = 1'b1;
      tick();
      idle();
      tests_run++;
      if (alert !== 1'b1 || dut_vec() !== exp_vec()) begin
         tests_failed++;
         $display("FAIL alert_beats_clear: got %h want %h", dut_vec(), exp_vec());
      end
      clear = 1'b1;
      tick();
      idle();
      tests_run++;
      if (alert !== 1'b0 || dut_vec() !== exp_vec()) begin
         tests_failed++;
         $display("FAIL alert_clear2: got %h want %h", dut_vec(), exp_vec());
      end
   endtask

   task automatic test_back_to_back();
      int issued = 0;
      bit saw_stall = 1'b0;
      instr = jalr(5'd1, 5'd5); instr_valid = 1'b1;
      pc = 32'h1000; tgt = 32'h2000;
      tick();
      if (push_v || pop_v) issued++;
      pc = 32'h1004; tgt = 32'h2004;
      tick();
      if (push_v || pop_v) issued++;
      tests_run++;
      if (stall !== 1'b1) begin
         tests_failed++;
         $display("FAIL stall_rise: got stall=%b want 1", stall);
      end
      pc = 32'h1008; tgt = 32'h2008;   // held valid while stalled: must be dropped
      tick();
      instr_valid = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tests_run++;
         if (dut_vec() !== exp_vec()) begin
            tests_failed++;
            $display("FAIL b2b_cycle%0d: got %h want %h", i, dut_vec(), exp_vec());
         end
         if (stall) saw_stall = 1'b1;
         if (push_v || pop_v) issued++;
         tick();
      end
      idle();
      tests_run++;
      if (issued != 4 || saw_stall || stall !== 1'b0) begin
         tests_failed++;
         $display("FAIL b2b_drain: got issued=%0d late_stall=%b stall=%b want 4 0 0", issued, saw_stall, stall);
      end
   endtask

   task automatic test_wrap_reset();
      instr = jal(5'd1); pc = 32'hFFFF_FFFC; instr_valid = 1'b1;
      tick();
      idle();
      tests_run++;
      if (push_v !== 1'b1 || push_a !== 32'h0) begin
         tests_failed++;
         $display("FAIL pc_wrap: got v=%b a=%h want v=1 a=00000000", push_v, push_a);
      end
      instr = jalr(5'd5, 5'd1); pc = 32'h40; tgt = 32'h80; instr_valid = 1'b1;
      tick();
      tick();
      idle();
      #2 rst_ni = 1'b0;
      mq.delete();
      m_alert = 1'b0;
      #1;
      tests_run++;
      if (dut_vec() !== 68'h0) begin
         tests_failed++;
         $display("FAIL async_reset: got %h want %h", dut_vec(), 68'h0);
      end
      @(negedge clk);
      rst_ni = 1'b1;
      tick();
      tests_run++;
      if (dut_vec() !== exp_vec()) begin
         tests_failed++;
         $display("FAIL reset_discard: got %h want %h", dut_vec(), exp_vec());
      end
   endtask

   function automatic logic [4:0] pick_reg();
      logic [4:0] r = 5'($urandom);
      case ($urandom_range(0, 3))
         0: return 5'd0;
         1: return 5'd1;
         2: return 5'd5;
         default: return r;
      endcase
   endfunction

   task automatic test_random();
      logic [31:0] rnd;
      logic [6:0]  op;
      logic [2:0]  f3;
      int          errs = 0;
      for (int c = 0; c < 3000; c++) begin
         tests_run++;
         if (dut_vec() !== exp_vec()) begin
            tests_failed++;
            errs++;
            if (errs <= 10) $display("FAIL random_c%0d: got %h want %h", c, dut_vec(), exp_vec());
         end
         rnd = $urandom;
         case ($urandom_range(0, 9))
            0, 1, 2, 3:       op = 7'h6f;
            4, 5, 6, 7, 8:    op = 7'h67;
            default:          op = 7'($urandom);
         endcase
         f3 = ($urandom_range(0, 7) == 0) ? 3'($urandom) : 3'd0;
         instr = {rnd[31:20], pick_reg(), f3, pick_reg(), op};
         comp  = $urandom_range(0, 2) == 0;
         pc    = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFE : {$urandom} & 32'hFFFF_FFFE;
         tgt   = $urandom;
         instr_valid = $urandom_range(0, 9) < 7;
         if (m_stall() && $urandom_range(0, 7) != 0) instr_valid = 1'b0;
         ss_error = $urandom_range(0, 24) == 0;
         clear    = $urandom_range(0, 4) == 0;
         tick();
      end
      idle();
   endtask

   initial begin
      test_reset();
      test_jal_push();
      test_call_return();
      test_coroutine();
      test_alert();
      test_back_to_back();
      test_wrap_reset();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
